// File: rtl/bus_block_mover.sv
// Bus-initiator block mover: copies or fills a run of words over the shared
// single-port memory bus. Bus outputs are registered and set on state entry.
module bus_block_mover #(
  parameter int data_width    = 8,
  parameter int address_width = 16,
  parameter int len_width     = 16,
  parameter int read_latency  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [address_width-1:0] src_addr,
  input  logic [address_width-1:0] dst_addr,
  input  logic [len_width-1:0]     length,
  input  logic [data_width-1:0]    fill_value,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [len_width-1:0]     words_done,
  output logic [address_width-1:0] bus_addr,
  output logic                     bus_wr,
  output logic [data_width-1:0]    bus_wdata,
  input  logic [data_width-1:0]    bus_rdata
);

  localparam int lat_w = (read_latency > 1) ? $clog2(read_latency) : 1;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

  state_t                   state;
  logic                     mode_q;
  logic [address_width-1:0] src_q;
  logic [address_width-1:0] dst_q;
  logic [len_width-1:0]     len_q;
  logic [data_width-1:0]    fill_q;
  logic [len_width-1:0]     idx;
  logic [lat_w-1:0]         wait_cnt;

  logic [len_width-1:0]     idx_inc;
  logic                     last_word;
  logic [address_width-1:0] dst_cur;
  logic [address_width-1:0] dst_next;
  logic [address_width-1:0] src_next;

  assign idx_inc   = idx + len_width'(1);
  assign last_word = (idx == len_q - len_width'(1));
  assign dst_cur   = dst_q + address_width'(idx);
  assign dst_next  = dst_q + address_width'(idx_inc);
  assign src_next  = src_q + address_width'(idx_inc);

  // Command fields are plain data: captured on an accepted start, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      mode_q <= mode;
      src_q  <= src_addr;
      dst_q  <= dst_addr;
      len_q  <= length;
      fill_q <= fill_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      words_done <= '0;
      bus_addr   <= '0;
      bus_wr     <= 1'b0;
      bus_wdata  <= '0;
    end else begin
      // Bus outputs default to idle; each transition sets what the next state drives.
      done      <= 1'b0;
      bus_wr    <= 1'b0;
      bus_wdata <= '0;
      bus_addr  <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            words_done <= '0;
            aborted    <= 1'b0;
            busy       <= 1'b1;
            if (length == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode) begin
              state     <= WR;
              bus_addr  <= dst_addr;
              bus_wr    <= 1'b1;
              bus_wdata <= fill_value;
            end else begin
              state    <= RD;
              bus_addr <= src_addr;
            end
          end
        end
        RD: begin
          if (abort) begin
            state   <= FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= lat_w'(read_latency - 1);
            bus_addr <= bus_addr;
          end
        end
        WAIT: begin
          if (abort) begin
            state   <= FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (wait_cnt == '0) begin
            state     <= WR;
            bus_addr  <= dst_cur;
            bus_wr    <= 1'b1;
            bus_wdata <= bus_rdata;
          end else begin
            wait_cnt <= wait_cnt - lat_w'(1);
            bus_addr <= bus_addr;
          end
        end
        WR: begin
          // The write presented this cycle always completes, even under abort.
          idx        <= idx_inc;
          words_done <= words_done + len_width'(1);
          if (abort || last_word) begin
            state   <= FIN;
            done    <= 1'b1;
            aborted <= abort;
          end else if (mode_q) begin
            bus_addr  <= dst_next;
            bus_wr    <= 1'b1;
            bus_wdata <= fill_q;
          end else begin
            state    <= RD;
            bus_addr <= src_next;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_block_mover.sv
// Scoreboard bench for bus_block_mover: a word-level reference model queues the
// expected bus writes and completions; a negedge monitor pops and compares.
module tb_bus_block_mover;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LW  = 16;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] length = '0;
  logic [DW-1:0] fill_value = '0;
  logic          abort = 1'b0;
  logic          busy, done, aborted, bus_wr;
  logic [LW-1:0] words_done;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  bus_block_mover #(
    .data_width(DW), .address_width(AW), .len_width(LW), .read_latency(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .words_done(words_done), .bus_addr(bus_addr),
    .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } wr_t;

  typedef struct {
    int   words;
    logic ab;
    int   busy_cyc;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    checks = 0;
  int    errors = 0;
  logic [DW-1:0] ram       [0:65535];
  logic [DW-1:0] model_mem [0:65535];
  logic [DW-1:0] rdata_q = '0;

  assign bus_rdata = rdata_q;

  function automatic logic [DW-1:0] seed_byte(input int a);
    if (a >= 16 && a <= 18) return DW'((a - 15) * 17);
    return DW'((a * 37) ^ (a >> 5));
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Responder: single-port RAM with one cycle read latency.
  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = seed_byte(a);
    forever begin
      @(posedge clk);
      if (bus_wr === 1'b1) ram[bus_addr] <= bus_wdata;
      rdata_q <= ram[bus_addr];
    end
  end

  // Word-level model of a complete operation.
  task automatic model_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int n, input logic [DW-1:0] f);
    done_t dn;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = AW'(d + i);
      w.data = m ? f : model_mem[AW'(s + i)];
      w.gap  = (i == 0) ? 0 : (m ? 1 : LAT + 2);
      model_mem[w.addr] = w.data;
      exp_wr.push_back(w);
    end
    dn.words    = n;
    dn.ab       = 1'b0;
    dn.busy_cyc = (n == 0) ? 1 : (m ? n + 1 : n * (LAT + 2) + 1);
    exp_done.push_back(dn);
  endtask

  task automatic issue(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input int n, input logic [DW-1:0] f);
    mode       = m;
    src_addr   = s;
    dst_addr   = d;
    length     = LW'(n);
    fill_value = f;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
  endtask

  task automatic run_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input int n, input logic [DW-1:0] f);
    model_op(m, s, d, n, f);
    issue(m, s, d, n, f);
    wait_done(400);
  endtask

  // Monitor
  initial begin
    int    cyc = 0;
    int    last_wr = -1000;
    int    busy_cnt = 0;
    wr_t   w;
    done_t d;
    repeat (3) @(negedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) busy_cnt++;
      if (bus_wr === 1'b1) begin
        if (exp_wr.size() == 0) begin
          check("wr_expected", exp_wr.size(), 1);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", bus_addr, w.addr);
          check("wr_data", bus_wdata, w.data);
          if (w.gap > 0) check("wr_gap", cyc - last_wr, w.gap);
        end
        last_wr = cyc;
      end
      if (done === 1'b1) begin
        check("fin_bus_wr", bus_wr, 0);
        if (exp_done.size() == 0) begin
          check("done_expected", exp_done.size(), 1);
        end else begin
          d = exp_done.pop_front();
          check("words_done", words_done, d.words);
          check("aborted", aborted, d.ab);
          if (d.busy_cyc >= 0) check("busy_cycles", busy_cnt, d.busy_cyc);
        end
      end
      if (busy !== 1'b1) begin
        check("idle_bus_wr", bus_wr, 0);
        check("idle_bus_addr", bus_addr, 0);
        check("idle_bus_wdata", bus_wdata, 0);
        check("idle_done", done, 0);
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    done_t dn;
    wr_t   w;
    for (int a = 0; a < 65536; a++) model_mem[a] = seed_byte(a);

    repeat (4) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_words_done", words_done, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wr", bus_wr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    @(negedge clk);

    run_op(1'b1, 16'h0000, 16'h0100, 4, 8'hA5);
    run_op(1'b0, 16'h0010, 16'h0200, 3, 8'h00);
    for (int i = 0; i < 3; i++) check("copy_readback", ram[16'h0200 + i], 8'((i + 1) * 17));
    run_op(1'b0, 16'h0040, 16'h0300, 0, 8'h00);
    run_op(1'b1, 16'h0000, 16'hFFFE, 4, 8'h3C);
    for (int i = 0; i < 4; i++) check("wrap_readback", ram[AW'(16'hFFFE + i)], 8'h3C);

    // Abort in the second word's WAIT: only the first word is written.
    w.addr = 16'h0400;
    w.data = model_mem[16'h0600];
    w.gap  = 0;
    model_mem[16'h0400] = w.data;
    exp_wr.push_back(w);
    dn.words = 1;
    dn.ab = 1'b1;
    dn.busy_cyc = -1;
    exp_done.push_back(dn);
    issue(1'b0, 16'h0600, 16'h0400, 8, 8'h00);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(20);
    check("aborted_held", aborted, 1);
    check("words_done_held", words_done, 1);
    @(negedge clk);
    run_op(1'b1, 16'h0000, 16'h0700, 2, 8'h96);

    // Reset mid-fill, with an ignored start issued while busy.
    for (int i = 0; i < 5; i++) begin
      w.addr = AW'(16'h0500 + i);
      w.data = 8'h5C;
      w.gap  = (i == 0) ? 0 : 1;
      model_mem[w.addr] = w.data;
      exp_wr.push_back(w);
    end
    issue(1'b1, 16'h0000, 16'h0500, 10, 8'h5C);
    @(negedge clk);
    mode = 1'b0;
    dst_addr = 16'h0900;
    fill_value = 8'h77;
    length = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_bus_wr", bus_wr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_words_done", words_done, 0);
    check("midrst_pending_wr", exp_wr.size(), 0);
    @(negedge clk);

    for (int k = 0; k < 30; k++) begin
      logic          m;
      logic [AW-1:0] s, d;
      logic [DW-1:0] f;
      int            n;
      m = 1'($urandom_range(0, 1));
      s = AW'($urandom);
      d = AW'($urandom);
      f = DW'($urandom);
      n = $urandom_range(0, 12);
      run_op(m, s, d, n, f);
    end

    repeat (3) @(negedge clk);
    check("leftover_writes", exp_wr.size(), 0);
    check("leftover_dones", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
